// File: rtl/spart_pkg.sv
// spart_pkg
// Shared definitions for the standalone SPART bus master (spart_driver) and
// its echo FIFO: SPART register addresses, controller state encoding, baud
// select encoding, the divisor arithmetic and the optional lower-to-upper
// ASCII conversion helper.
package spart_pkg;

    // SPART processor-side register addresses
    localparam logic [1:0] ADDR_DATA = 2'b00;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    // Controller states: two divisor-programming cycles, then the echo loop
    typedef enum logic [2:0] {
        ST_CFG_LO = 3'd0,
        ST_CFG_HI = 3'd1,
        ST_IDLE   = 3'd2,
        ST_RD     = 3'd3,
        ST_WR     = 3'd4,
        ST_HOLD   = 3'd5
    } state_e;

    // Baud select encoding as seen on br_cfg
    typedef enum logic [1:0] {
        BAUD_4800  = 2'b00,
        BAUD_9600  = 2'b01,
        BAUD_19200 = 2'b10,
        BAUD_38400 = 2'b11
    } baud_sel_e;

    // Divisor for a given clock and baud rate: clk/(16*baud) - 1, truncated
    // to the 16 bits the SPART divisor register pair holds.
    function automatic logic [15:0] calc_div(int unsigned clk_hz, int unsigned baud);
        int unsigned q;
        q = clk_hz / (16 * baud) - 1;
        return q[15:0];
    endfunction

    // Map ASCII 'a'..'z' onto 'A'..'Z' by clearing bit 5; everything else
    // passes through untouched.
    function automatic logic [7:0] ascii_upcase(logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (b >= 8'h61 && b <= 8'h7A) begin
            r = b & 8'hDF;
        end
        return r;
    endfunction

endpackage

// File: rtl/spart_driver_if.sv
// spart_driver_if
// Processor-side SPART bus: chip select, read/write, address, the shared
// 8-bit data bus and the two status flags.
//   master (spart_driver): drives iocs/iorw/ioaddr and db_out/db_oe,
//                          reads databus, rda, tbr
//   slave  (SPART side)  : drives spart_dout/spart_oe, rda, tbr,
//                          reads iocs/iorw/ioaddr and databus
// databus is the resolved shared bus; each side only offers data through
// its own output-enable, and the bus floats when neither enable is set.
interface spart_driver_if;

    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] db_out;
    logic       db_oe;
    logic [7:0] spart_dout;
    logic       spart_oe;
    logic       rda;
    logic       tbr;
    wire  [7:0] databus;

    // Master wins if both enables were ever set; normally they are exclusive
    // because the SPART only drives during a read and the master only during
    // a write.
    assign databus = db_oe ? db_out : (spart_oe ? spart_dout : 8'bz);

    modport master (
        output iocs, iorw, ioaddr, db_out, db_oe,
        input  databus, rda, tbr
    );

    modport slave (
        input  iocs, iorw, ioaddr, databus,
        output spart_dout, spart_oe, rda, tbr
    );

endinterface

// File: rtl/spart_echo_fifo.sv
// spart_echo_fifo
// Small synchronous circular FIFO that buffers received bytes until the
// SPART transmitter can accept them.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write din_i at the clock edge (ignored when full)
//   pop_i      : drop the head entry at the clock edge (ignored when empty)
//   din_i      : byte to push
//   dout_o     : current head entry (valid when not empty)
//   count_o    : occupancy, 0..DEPTH
//   full_o, empty_o : occupancy flags
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
module spart_echo_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping. The controller never pushes and
    // pops in the same cycle, so the two cases are handled exclusively.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (push_i && !full_o) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            count_q  <= count_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q  <= count_q - 1'b1;
        end
    end

    // Storage has no reset; entries only become visible through the pointers.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/spart_driver.sv
// spart_driver
// Bus-master sequencer that stands in for a CPU in the standalone SPART
// build. After reset, and whenever br_cfg changes, it writes the baud
// divisor (low byte then high byte); otherwise it polls rda/tbr, reads
// received bytes into a small FIFO and writes them back out (echo).
//   clk      : system clock
//   rst      : asynchronous reset, active-low
//   br_cfg   : baud select 00=4800 01=9600 10=19200 11=38400
//   bus      : SPART processor bus (iocs, iorw, ioaddr, databus, rda, tbr)
//   cfg_done : high while the loaded divisor matches br_cfg
//   fifo_cnt : echo FIFO occupancy
//   ovf      : sticky, rda seen while the FIFO was full
// Optional build macro SPART_DRIVER_UPCASE_EN: when defined, lower-case
// ASCII letters are converted to upper case as they enter the FIFO.
module spart_driver
    import spart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    br_cfg,
    spart_driver_if.master                bus,
    output logic                          cfg_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          ovf
);

    localparam logic [15:0] DIV_4800  = calc_div(CLK_HZ, 4800);
    localparam logic [15:0] DIV_9600  = calc_div(CLK_HZ, 9600);
    localparam logic [15:0] DIV_19200 = calc_div(CLK_HZ, 19200);
    localparam logic [15:0] DIV_38400 = calc_div(CLK_HZ, 38400);

    state_e     state_q, state_d;
    logic       run_q;
    logic [1:0] br_cfg_q, br_cfg_d;
    logic       cfg_done_q, cfg_done_d;
    logic       ovf_q, ovf_d;

    logic       fifo_push, fifo_pop;
    logic [7:0] fifo_din, fifo_dout;
    logic       fifo_full, fifo_empty;
    logic [15:0] div_val;

    // Divisor for the latched baud select
    always_comb begin
        div_val = DIV_9600;
        case (baud_sel_e'(br_cfg_q))
            BAUD_4800:  div_val = DIV_4800;
            BAUD_9600:  div_val = DIV_9600;
            BAUD_19200: div_val = DIV_19200;
            BAUD_38400: div_val = DIV_38400;
            default:    div_val = DIV_9600;
        endcase
    end

    // Byte captured from the bus during RD, optionally upper-cased on entry
    always_comb begin
`ifdef SPART_DRIVER_UPCASE_EN
        fifo_din = ascii_upcase(bus.databus);
`else
        fifo_din = bus.databus;
`endif
    end

    spart_echo_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (fifo_din),
        .dout_o  (fifo_dout),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // State register plus the latched baud select and status flags.
    // run_q marks that the first clock after reset has happened: that clock
    // samples br_cfg, so the first divisor write can only follow it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_CFG_LO;
            run_q      <= 1'b0;
            br_cfg_q   <= 2'b00;
            cfg_done_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            br_cfg_q   <= br_cfg_d;
            cfg_done_q <= cfg_done_d;
            ovf_q      <= ovf_d;
        end
    end

    // Next-state logic. Every bus access is a single cycle; RD and WR are
    // always followed by HOLD so the SPART has time to drop rda/tbr before
    // they are polled again.
    always_comb begin
        state_d    = state_q;
        br_cfg_d   = br_cfg_q;
        cfg_done_d = cfg_done_q;
        ovf_d      = ovf_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;

        if (!run_q) begin
            br_cfg_d = br_cfg;
        end

        case (state_q)
            ST_CFG_LO: begin
                if (run_q) begin
                    state_d = ST_CFG_HI;
                end
            end
            ST_CFG_HI: begin
                state_d    = ST_IDLE;
                cfg_done_d = 1'b1;
            end
            ST_IDLE: begin
                if (bus.rda && fifo_full) begin
                    ovf_d = 1'b1;
                end
                if (br_cfg != br_cfg_q) begin
                    br_cfg_d   = br_cfg;
                    cfg_done_d = 1'b0;
                    state_d    = ST_CFG_LO;
                end else if (bus.rda && !fifo_full) begin
                    state_d = ST_RD;
                end else if (bus.tbr && !fifo_empty) begin
                    state_d = ST_WR;
                end
            end
            ST_RD: begin
                fifo_push = 1'b1;
                state_d   = ST_HOLD;
            end
            ST_WR: begin
                fifo_pop = 1'b1;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CFG_LO;
            end
        endcase
    end

    // Bus outputs decode only the state register (never rda/tbr), and are
    // forced idle in reset and in the br_cfg sampling cycle after it.
    always_comb begin
        bus.iocs   = 1'b0;
        bus.iorw   = 1'b1;
        bus.ioaddr = ADDR_DATA;
        bus.db_out = 8'h00;
        bus.db_oe  = 1'b0;
        if (run_q) begin
            case (state_q)
                ST_CFG_LO: begin
                    bus.iocs   = 1'b1;
                    bus.iorw   = 1'b0;
                    bus.ioaddr = ADDR_DBL;
                    bus.db_out = div_val[7:0];
                    bus.db_oe  = 1'b1;
                end
                ST_CFG_HI: begin
                    bus.iocs   = 1'b1;
                    bus.iorw   = 1'b0;
                    bus.ioaddr = ADDR_DBH;
                    bus.db_out = div_val[15:8];
                    bus.db_oe  = 1'b1;
                end
                ST_RD: begin
                    bus.iocs   = 1'b1;
                    bus.iorw   = 1'b1;
                    bus.ioaddr = ADDR_DATA;
                end
                ST_WR: begin
                    bus.iocs   = 1'b1;
                    bus.iorw   = 1'b0;
                    bus.ioaddr = ADDR_DATA;
                    bus.db_out = fifo_dout;
                    bus.db_oe  = 1'b1;
                end
                default: begin
                    bus.iocs = 1'b0;
                end
            endcase
        end
    end

    // cfg_done drops as soon as br_cfg no longer matches the loaded divisor,
    // not just once reprogramming starts.
    assign cfg_done = cfg_done_q && (br_cfg == br_cfg_q);
    assign ovf      = ovf_q;

endmodule
